// File: rtl/text_line_ctrl.sv
// Text line controller: buffers a short message of glyph codes and, per pixel,
// tells a shared glyph renderer which glyph (if any) covers the current pixel,
// with optional frame-based blinking. All outputs are registered (1-cycle latency).
module text_line_ctrl #(
  parameter int PITCH        = 32,
  parameter int CHAR_H       = 40,
  parameter int MAX_CHARS    = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_tick,
  input  logic [9:0] base_x,
  input  logic [9:0] base_y,
  input  logic       blink_en,
  input  logic       msg_clear,
  input  logic       load_valid,
  input  logic [4:0] load_code,
  input  logic       load_last,
  output logic       load_ready,
  output logic [9:0] glyph_start_x,
  output logic [9:0] glyph_start_y,
  output logic [4:0] glyph_code,
  output logic       glyph_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [3:0] msg_len
);

  localparam int SHIFT = $clog2(PITCH);
  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_FRAME, SHOW, HIDE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   blink_cnt, blink_cnt_next;
  logic [3:0]         wr_ptr;
  logic [4:0]         msg_buf [MAX_CHARS];

  logic               ready_int;
  logic               show_active;
  logic               accept;
  logic               last_beat;

  logic [10:0]        dx;
  logic [10:0]        slot;
  logic [10:0]        origin;
  logic               hit;
  logic               vis;

  assign accept    = load_valid && load_ready;
  // The final slot closes the message even without load_last.
  assign last_beat = load_last || (wr_ptr == 4'(MAX_CHARS - 1));

  // State and blink counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blink_cnt <= '0;
    end else begin
      state     <= state_next;
      blink_cnt <= blink_cnt_next;
    end
  end

  // Next-state logic; msg_clear overrides every other transition.
  always_comb begin
    state_next     = state;
    blink_cnt_next = blink_cnt;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          state_next     = last_beat ? WAIT_FRAME : LOAD;
          blink_cnt_next = '0;
        end
      end
      WAIT_FRAME: begin
        if (frame_tick) begin
          state_next     = SHOW;
          blink_cnt_next = '0;
        end
      end
      SHOW: begin
        if (!blink_en) begin
          blink_cnt_next = '0;
        end else if (frame_tick) begin
          if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            state_next     = HIDE;
            blink_cnt_next = '0;
          end else begin
            blink_cnt_next = blink_cnt + 1'b1;
          end
        end
      end
      HIDE: begin
        if (frame_tick) begin
          if (!blink_en || (blink_cnt == CNT_W'(BLINK_FRAMES - 1))) begin
            state_next     = SHOW;
            blink_cnt_next = '0;
          end else begin
            blink_cnt_next = blink_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        blink_cnt_next = '0;
      end
    endcase
    if (msg_clear) begin
      state_next     = IDLE;
      blink_cnt_next = '0;
    end
  end

  // State-decoded controls: ready while accepting, display while showing.
  always_comb begin
    ready_int   = 1'b0;
    show_active = 1'b0;
    case (state)
      IDLE, LOAD: ready_int   = 1'b1;
      SHOW:       show_active = 1'b1;
      default:    ;
    endcase
  end

  // Ready is held low while reset is asserted.
  assign load_ready = ready_int && rst_n;
  assign msg_len    = wr_ptr;

  // Write pointer doubles as the stored message length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (msg_clear) begin
      wr_ptr <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 4'd1;
    end
  end

  // Message buffer; contents need no reset since msg_len gates every read.
  always_ff @(posedge clk) begin
    if (accept && !msg_clear) begin
      msg_buf[wr_ptr[IDX_W-1:0]] <= load_code;
    end
  end

  // Pixel-to-slot mapping in 11 bits so origins past the right edge are caught.
  always_comb begin
    dx     = {1'b0, x} - {1'b0, base_x};
    slot   = dx >> SHIFT;
    origin = {1'b0, base_x} + (slot << SHIFT);
    hit    = (x >= base_x)
          && (slot < {7'd0, wr_ptr})
          && ({1'b0, y} >= {1'b0, base_y})
          && ({1'b0, y} < ({1'b0, base_y} + 11'(CHAR_H)))
          && (origin <= 11'd1023);
    vis    = hit && show_active;
  end

  // Registered renderer outputs; glyph fields read as 0 whenever not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_en      <= 1'b0;
      glyph_start_x <= '0;
      glyph_start_y <= '0;
      glyph_code    <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
    end else begin
      glyph_en      <= vis;
      glyph_start_x <= vis ? origin[9:0] : 10'd0;
      glyph_start_y <= vis ? base_y : 10'd0;
      glyph_code    <= vis ? msg_buf[slot[IDX_W-1:0]] : 5'd0;
      pix_x         <= x;
      pix_y         <= y;
    end
  end

endmodule

// File: doc/text_line_ctrl.md
TEXT_LINE_CTRL -- requirements
Module: text_line_ctrl

Interface
REQ-001 SHALL have parameter PITCH, default 32: horizontal glyph-to-glyph spacing in pixels (power of two).
REQ-002 SHALL have parameter CHAR_H, default 40: glyph height in pixels.
REQ-003 SHALL have parameter MAX_CHARS, default 8: message buffer depth.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30: frames per blink phase.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports x and y, input, 10 each: current pixel position.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse per frame.
REQ-009 SHALL have ports base_x and base_y, input, 10 each: top-left of slot 0; quasi-static.
REQ-010 SHALL have port blink_en, input, 1: enables blinking.
REQ-011 SHALL have port msg_clear, input, 1: pulse that discards the message.
REQ-012 SHALL have ports load_valid (input, 1), load_code (input, 5), load_last (input, 1) and load_ready (output, 1): character load handshake.
REQ-013 SHALL have ports glyph_start_x and glyph_start_y, output, 10 each: origin for the shared glyph renderer.
REQ-014 SHALL have port glyph_code, output, 5: selects the glyph.
REQ-015 SHALL have port glyph_en, output, 1: renderer output is valid.
REQ-016 SHALL have ports pix_x and pix_y, output, 10 each: x and y delayed one cycle.
REQ-017 SHALL have port msg_len, output, 4: number of stored characters.

Function
REQ-018 SHALL implement states IDLE, LOAD, WAIT_FRAME, SHOW and HIDE.
REQ-019 SHALL drive load_ready=1 only in IDLE and LOAD; a beat is accepted when load_valid and load_ready are both 1.
REQ-020 SHALL write an accepted beat's code to buf[wr_ptr], increment wr_ptr and set msg_len=wr_ptr+1; a beat accepted in IDLE also moves IDLE to LOAD and writes slot 0.
REQ-021 SHALL go to WAIT_FRAME on an accepted beat with load_last=1, or on the MAX_CHARS-th beat; that beat is stored and a ninth beat is never accepted.
REQ-022 SHALL move WAIT_FRAME to SHOW on frame_tick and clear the blink counter.
REQ-023 SHALL, in SHOW with blink_en=1, increment the blink counter on each frame_tick; a tick at count BLINK_FRAMES-1 moves to HIDE and zeroes the counter. HIDE returns to SHOW the same way.
REQ-024 SHALL move HIDE to SHOW on the next frame_tick when blink_en=0; SHOW holds with the counter at 0 while blink_en=0.
REQ-025 SHALL, on msg_clear in any state, go to IDLE next cycle with wr_ptr=0 and msg_len=0; msg_clear has priority over a simultaneous beat, frame_tick or blink transition.
REQ-026 SHALL compute dx = x - base_x in 11-bit arithmetic and slot = dx / PITCH (shift).
REQ-027 SHALL treat a pixel as hit when x >= base_x, slot < msg_len, base_y <= y < base_y+CHAR_H, and base_x + slot*PITCH <= 1023 (11-bit compare).
REQ-028 SHALL register all outputs with one-cycle latency: glyph_en = hit and state==SHOW; glyph_start_x = base_x + slot*PITCH; glyph_start_y = base_y; glyph_code = buf[slot]; pix_x and pix_y = x and y of the previous cycle.
REQ-029 SHALL hold glyph_start_x, glyph_start_y and glyph_code at 0 when glyph_en=0.
REQ-030 SHALL keep glyph_en=0 in IDLE, LOAD, WAIT_FRAME and HIDE.

Reset
REQ-031 SHALL, while rst_n=0 (asynchronous), force state IDLE, wr_ptr=0, msg_len=0, blink counter=0, and all outputs 0 except load_ready=1 once out of reset; buffer contents are don't-care.
REQ-032 SHALL, on reset asserted mid-load or mid-display, drop glyph_en to 0 immediately and discard the message.

Verification
REQ-033 SHALL check: load codes 3,7,1 (last on the 3rd beat), then frame_tick, base=(100,50), pixel (133,60) -> one cycle later glyph_en=1, start=(132,50), code=7, pix=(133,60).
REQ-034 SHALL check: 8 beats with load_last=0 -> load_ready=0 after the 8th, msg_len=8, state WAIT_FRAME, a 9th beat not accepted.
REQ-035 SHALL check: SHOW with blink_en=1 and BLINK_FRAMES=2 -> glyph_en active 2 frames, 0 for 2 frames, then active again.
REQ-036 SHALL check: base_x=900, msg_len=8, x=1000 -> slot 3 is hit; slots 4..7 (origin > 1023) are never hit and no wrapped origin is output.
REQ-037 SHALL check: msg_clear in the same cycle as load_valid and frame_tick -> IDLE, msg_len=0, beat dropped, glyph_en=0.
REQ-038 SHALL check: rst_n low for 1 cycle during SHOW -> outputs 0 asynchronously, IDLE after release, msg_len=0.
